// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings and baud helper.
// The helper is reused by the transmit side, so it takes frequencies explicitly.
package uart_rx_byte_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  localparam int DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
// RST_VAL is chosen so that the synchronizer output matches the line's idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver that writes each good byte into the downstream byte FIFO.
// Framing errors and FIFO overruns are reported as one-cycle pulses; the block never stalls.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       fifo_full,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             bit_idx_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   wr_en_q, frame_err_q, overrun_q;
  logic [DATA_BITS-1:0]   wr_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= cnt_q + 1'b1;
      unique case (state_q)
        S_WAIT_IDLE: if (rx_s) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        S_IDLE: if (!rx_s) begin
          state_q <= S_START;
          cnt_q   <= '0;
        end
        // Mid-start re-check rejects glitches shorter than half a bit.
        S_START: if (cnt_q == HALF_M1) begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          state_q   <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (cnt_q == BIT_M1) begin
          cnt_q   <= '0;
          shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_idx_q == 3'd7) state_q   <= S_STOP;
          else                   bit_idx_q <= bit_idx_q + 3'd1;
        end
        // Leaving at mid-stop leaves half a bit of margin to catch a back-to-back start edge.
        S_STOP: if (cnt_q == BIT_M1) begin
          cnt_q <= '0;
          if (!rx_s) begin
            frame_err_q <= 1'b1;
            state_q     <= S_WAIT_IDLE;
          end else begin
            state_q <= S_IDLE;
            if (fifo_full) overrun_q <= 1'b1;
            else begin
              wr_en_q   <= 1'b1;
              wr_data_q <= shreg_q;
            end
          end
        end
        default: begin
          state_q <= S_WAIT_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomised and directed bench for uart_rx_byte with a frame-level reference model
// feeding an expected-event queue that an independent monitor drains.
module tb_uart_rx_byte;

  localparam int CPB = 104;
  localparam logic [2:0] K_WR = 3'b100, K_FE = 3'b010, K_OV = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       fifo_full = 1'b0;
  logic       wr_en, frame_err, overrun, busy;
  logic [7:0] wr_data;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [7:0] last_byte = 8'h00;
  logic lowwin = 1'b0;
  time  t_edge, t_wr;

  uart_rx_byte dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Frame-level model: a frame yields exactly one event decided by stop level and FIFO state.
  task automatic expect_frame(input logic [7:0] b, input logic stop_ok, input logic full);
    exp_t e;
    if (!stop_ok)   e.kind = K_FE;
    else if (full)  e.kind = K_OV;
    else begin
      e.kind    = K_WR;
      last_byte = b;
    end
    e.data = last_byte;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    t_edge = $time;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && (wr_en || frame_err || overrun)) begin
      checks++;
      if ($countones({wr_en, frame_err, overrun}) != 1) begin
        errors++;
        $display("FAIL exclusive: wr_en=%b frame_err=%b overrun=%b", wr_en, frame_err, overrun);
      end
      if (lowwin) begin
        if (wr_en || overrun) begin
          errors++;
          $display("FAIL low_window: wr_en=%b overrun=%b while line held low", wr_en, overrun);
        end
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: kind=%b data=%h", {wr_en, frame_err, overrun}, wr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({wr_en, frame_err, overrun} !== e.kind || wr_data !== e.data) begin
          errors++;
          $display("FAIL event: kind=%b data=%h expected kind=%b data=%h",
                   {wr_en, frame_err, overrun}, wr_data, e.kind, e.data);
        end
        if (wr_en) t_wr = $time;
      end
    end
  end

  initial begin
    string hello = "Hello";
    int    n;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 1);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);

    // Single 'H' with latency check.
    expect_frame(8'h48, 1'b1, 1'b0);
    send_frame(8'h48, 1'b1);
    repeat (20) @(negedge clk);
    drain(2000);
    n = int'((t_wr - t_edge) / 10);
    checks++;
    if (n < 989 || n > 993) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected 991 +/-2", n);
    end

    // 30-cycle glitch: rejected, busy drops by ~55 cycles after the edge.
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_hi", busy, 1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    n = 30;
    while (busy && n < 70) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n > 57) begin
      errors++;
      $display("FAIL glitch_busy_lo: busy still high %0d cycles after edge, required <=57", n);
    end
    repeat (50) @(negedge clk);

    // Framing error, line stuck low, then normal byte.
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0);
    repeat (500) @(negedge clk);
    check("ferr_wait_busy", busy, 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    expect_frame(8'h0C, 1'b1, 1'b0);
    send_frame(8'h0C, 1'b1);
    repeat (10) @(negedge clk);
    drain(2000);

    // Overrun, then recovery.
    fifo_full = 1'b1;
    expect_frame(8'h41, 1'b1, 1'b1);
    send_frame(8'h41, 1'b1);
    repeat (10) @(negedge clk);
    fifo_full = 1'b0;
    expect_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1);
    repeat (10) @(negedge clk);
    drain(2000);

    // "Hello" with no idle gap.
    for (int i = 0; i < 5; i++) expect_frame(hello[i], 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1);
    repeat (10) @(negedge clk);
    drain(2000);

    // Reset during DATA bit 4, release with the line low.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_frame_err", frame_err, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_wr_data", wr_data, 0);
    last_byte = 8'h00;
    lowwin = 1'b1;
    rst = 1'b0;
    repeat (1200) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    lowwin = 1'b0;
    check("post_rst_busy", busy, 0);
    expect_frame(8'h57, 1'b1, 1'b0);
    send_frame(8'h57, 1'b1);
    repeat (10) @(negedge clk);
    drain(2000);

    // Randomised frames: random data, FIFO state, stop level and gaps.
    for (int f = 0; f < 24; f++) begin
      logic [7:0] b;
      logic       stop_ok, full;
      b       = 8'($urandom);
      full    = ($urandom_range(0, 3) == 0);
      stop_ok = ($urandom_range(0, 4) != 0);
      fifo_full = full;
      expect_frame(b, stop_ok, full);
      send_frame(b, stop_ok);
      if (!stop_ok) begin
        repeat ($urandom_range(0, 150)) @(negedge clk);
        rx = 1'b1;
        repeat ($urandom_range(4, 20)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    fifo_full = 1'b0;
    drain(3000);
    repeat (20) @(negedge clk);
    check("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
